reg_share_arbiter: RTL

Round-robin arbiter that shares one W-bit synchronous-clear register bank between N requesters. A requester raises `req`, receives a registered one-hot `grant`, and its `wdata` is written into the shared register on every clock edge where both its grant and req are high. Ownership is bounded by `MAX_HOLD` transfers when other requesters are waiting. The block sits in front of the lab's shared D-flip-flop register stage and sequences all writes to it.

---
 rtl/reg_share_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sequencing N requesters onto one shared W-bit register.
// Ownership is capped at MAX_HOLD transfers whenever another requester waits.
module reg_share_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  localparam int PW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = $clog2(MAX_HOLD + 1)
) (
  input  logic            clock,
  input  logic            clearb,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  wdata,
  input  logic            clr_req,
  output logic [N-1:0]    grant,
  output logic [PW-1:0]   owner,
  output logic [W-1:0]    q,
  output logic            valid
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_grant;
  logic [PW-1:0]   r_owner;
  logic [W-1:0]    r_q;
  logic            r_valid;

  state_t          w_state_nx;
  logic [PW-1:0]   w_ptr_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic [N-1:0]    w_grant_nx;
  logic [PW-1:0]   w_owner_nx;
  logic            w_xfer;
  logic            w_release;

  logic [W-1:0]    w_wd [N];
  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic [N-1:0]    w_own_mask;
  logic            w_own_req;
  logic            w_others;

  for (genvar gi = 0; gi < N; gi++) begin : g_split
    assign w_wd[gi] = wdata[gi*W +: W];
  end

  // Winner is the set req bit at the smallest rotational distance from ptr.
  always_comb begin
    int best_d;
    int d;
    best_d   = N;
    w_winner = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(r_ptr)) % N;
      if (req[i] && (d < best_d)) begin
        best_d   = d;
        w_winner = PW'(i);
      end
    end
  end

  assign w_any      = |req;
  assign w_own_mask = {{(N-1){1'b0}}, 1'b1} << r_owner;
  assign w_own_req  = req[r_owner];
  assign w_others   = |(req & ~w_own_mask);

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_grant_nx = r_grant;
    w_owner_nx = r_owner;
    w_xfer     = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx = OWN;
          w_grant_nx = {{(N-1){1'b0}}, 1'b1} << w_winner;
          w_owner_nx = w_winner;
          w_cnt_nx   = '0;
        end
      end
      OWN: begin
        if (w_own_req) begin
          w_xfer   = 1'b1;
          w_cnt_nx = (r_cnt == CW'(MAX_HOLD)) ? r_cnt : r_cnt + 1'b1;
        end
        // A saturated counter keeps this true, so a late competitor forces release too.
        w_release = !w_own_req || ((w_cnt_nx == CW'(MAX_HOLD)) && w_others);
        if (w_release) begin
          w_state_nx = IDLE;
          w_grant_nx = '0;
          w_ptr_nx   = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clearb) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_grant <= w_grant_nx;
      r_owner <= w_owner_nx;
    end
  end

  // Clear wins over a same-edge transfer; the FSM still counts that transfer.
  always_ff @(posedge clock) begin
    if (!clearb || clr_req) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_q     <= w_wd[r_owner];
      r_valid <= 1'b1;
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign q     = r_q;
  assign valid = r_valid;

endmodule
